// File: rtl/cacheline_adapter_pkg.sv
// Shared cache types: line/beat geometry and the dfp-to-burst adapter state encoding.
package cacheline_adapter_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;

    // Clears the byte-offset bits so bursts always start on a line boundary.
    localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Turns one cacheline fill or writeback from the cache's dfp port into a
// 4-beat 64-bit burst, and packs read beats back into a full line.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    adapter_state_t    state;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_next;
    logic [LINE_W-1:0] wr_line;
    logic              rd_beat;

    assign count_next = count + 2'd1;

    // A beat landing in the same cycle as the command handshake is beat 0.
    assign rd_beat = mem_rvalid &&
                     ((state == RD_DATA) || ((state == RD_CMD) && mem_ready));

    always_comb begin
        line_next = line_buf;
        line_next[int'(count)*BEAT_W +: BEAT_W] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && dfp_write) begin
            wr_line <= dfp_wdata;
        end
        if (rd_beat) begin
            line_buf <= line_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            dfp_rdata <= '0;
            dfp_resp  <= 1'b0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (dfp_write) begin
                        state     <= WR_DATA;
                        mem_addr  <= dfp_addr & LINE_ADDR_MASK;
                        mem_write <= 1'b1;
                        mem_wdata <= dfp_wdata[BEAT_W-1:0];
                    end else if (dfp_read) begin
                        state    <= RD_CMD;
                        mem_addr <= dfp_addr & LINE_ADDR_MASK;
                        mem_read <= 1'b1;
                    end
                end
                RD_CMD: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        state    <= RD_DATA;
                        if (mem_rvalid) begin
                            count <= count_next;
                        end
                    end
                end
                RD_DATA: begin
                    if (mem_rvalid) begin
                        count <= count_next;
                        if (count == 2'(BEATS-1)) begin
                            state     <= RESP;
                            dfp_resp  <= 1'b1;
                            dfp_rdata <= line_next;
                        end
                    end
                end
                WR_DATA: begin
                    // Beat data and valid stay put until the memory accepts them.
                    if (mem_ready) begin
                        count <= count_next;
                        if (count == 2'(BEATS-1)) begin
                            mem_write <= 1'b0;
                            state     <= RESP;
                            dfp_resp  <= 1'b1;
                        end else begin
                            mem_wdata <= wr_line[int'(count_next)*BEAT_W +: BEAT_W];
                        end
                    end
                end
                RESP: begin
                    dfp_resp <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits directly downstream of the cache controller's dfp port.
- Converts one 256-bit cacheline read (readmem state) or writeback into a 4-beat, 64-bit burst on the burst-memory port.
- Packs read beats into a line and returns a single-cycle completion to the cache.
- The cache holds its request stable until it receives dfp_resp.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BEAT_W, 64, memory data width per beat.
- BEATS, LINE_W/BEAT_W (=4), beats per burst; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- dfp_addr  in  32  line address from cache; bits [4:0] are ignored.
- dfp_read  in  1  line fill request.
- dfp_write  in  1  line writeback request.
- dfp_wdata  in  LINE_W  writeback line.
- dfp_rdata  out  LINE_W  filled line; valid when dfp_resp=1.
- dfp_resp  out  1  one-cycle completion pulse.
- mem_addr  out  32  burst address, {dfp_addr[31:5],5'b0}.
- mem_read  out  1  burst read command.
- mem_write  out  1  write beat valid.
- mem_wdata  out  BEAT_W  write beat data.
- mem_ready  in  1  memory accepts a command or write beat this cycle.
- mem_rdata  in  BEAT_W  read beat data.
- mem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat count=0. All outputs are 0: dfp_rdata, dfp_resp, mem_addr, mem_read, mem_write, mem_wdata.
- All outputs are registered.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - dfp_write=1: latch addr and wdata, go to WR_DATA.
  - else dfp_read=1: latch addr, go to RD_CMD.
  - If both are asserted, write wins (illegal from cache, but defined).
- RD_CMD:
  - mem_read=1 and mem_addr are valid from the cycle after acceptance.
  - mem_read is held until a cycle with mem_ready=1.
  - mem_read drops the next cycle; go to RD_DATA.
- RD_DATA:
  - Each mem_rvalid=1 cycle writes mem_rdata into line slice [64*k+63:64*k], k=count, then count++.
  - Beat 0 maps to bits [63:0].
  - Gaps between beats are allowed.
  - On the 4th beat, go to RESP.
  - rvalid arriving in the same cycle as the command handshake is legal and is captured as beat 0.
- WR_DATA:
  - mem_write=1, mem_addr valid, mem_wdata = latched line slice k.
  - k advances only in cycles where mem_ready=1; data and valid are held while mem_ready=0.
  - After beat 3 is accepted, mem_write=0 and go to RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle, then IDLE.
  - For reads, dfp_rdata holds the assembled line and stays stable until the next read completes.
  - Writes do not modify dfp_rdata.
- The request is not re-sampled during RESP. A new request is accepted no earlier than the cycle after the RESP cycle.
- mem_rvalid outside RD_DATA is ignored (no state change, no error).
- The count is 2 bits, wraps 3->0, and is cleared on entry to any burst.
- Reset asserted mid-burst: immediate return to IDLE, no dfp_resp, partial line discarded.
- Minimum latencies (zero memory wait):
  - Write: accept -> resp = 6 cycles.
  - Read: 2 + memory read latency + 4 beats + 1.

Decomposition:
- Add to the shared cache types package:
  - typedef enum adapter_state_t {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP}.
  - Constants LINE_W=256, BEAT_W=64, BEATS=4, OFFSET_BITS=5.
- No sub-module. The beat counter and line pack/unpack muxing are inline.

Test Plan:
- Fill: dfp_read, addr 0x0000_1234; mem_ready=1; rvalid beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_addr=0x0000_1220 with mem_read high for 1 cycle; one dfp_resp pulse; dfp_rdata={44..,33..,22..,11..}.
- Writeback: dfp_write, addr 0x8000_0040, wdata={D,C,B,A}; mem_ready=1 -> mem_write high 4 consecutive cycles with wdata A,B,C,D; dfp_resp 1 cycle after beat D.
- Backpressure: writeback with mem_ready low for 3 cycles before beat 1 and 2 cycles before beat 3 -> each beat is held stable while not ready; no beat skipped or duplicated; resp only after beat 3 is accepted.
- Read gaps and strays: rvalid pulses in IDLE, then a fill with 2-cycle gaps between beats -> stray pulses ignored; line assembled correctly; exactly one dfp_resp.
- Simultaneous dfp_read and dfp_write=1 -> write burst performed; no mem_read.
- Reset: rst_n dropped after beat 2 of a read, released, then new read 0x100 -> outputs 0 immediately; no resp for the aborted read; new read completes normally with count starting at beat 0.
